// File: rtl/pcd8544_pkg.sv
// Shared constants for the PCD8544 receive-side decoder: geometry, opcodes,
// FSM encoding and the frame-buffer index helper.
package pcd8544_pkg;

  localparam int COLS     = 84;
  localparam int ROWS     = 6;
  localparam int FB_DEPTH = 504;

  localparam logic [7:0] FUNC_SET_MASK  = 8'hF8;
  localparam logic [7:0] FUNC_SET_VAL   = 8'h20;
  localparam logic [7:0] DISP_CTRL_MASK = 8'hFA;
  localparam logic [7:0] DISP_CTRL_VAL  = 8'h08;
  localparam logic [7:0] SET_Y_MASK     = 8'hF8;
  localparam logic [7:0] SET_Y_VAL      = 8'h40;
  localparam logic [7:0] SET_X_MASK     = 8'h80;
  localparam logic [7:0] SET_X_VAL      = 8'h80;
  localparam logic [7:0] SET_VOP_MASK   = 8'h80;
  localparam logic [7:0] SET_VOP_VAL    = 8'h80;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  // y*84 built from shifts so no multiplier is inferred.
  function automatic logic [8:0] fb_index(input logic [6:0] x, input logic [2:0] y);
    logic [8:0] yy;
    yy = {6'd0, y};
    return (yy << 6) + (yy << 4) + (yy << 2) + {2'd0, x};
  endfunction

endpackage

// File: rtl/pcd8544_rx_sync_edge.sv
// Multi-stage pin synchronizer with rising/falling edge detection on the
// synchronized value.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/pcd8544_rx.sv
// PCD8544 SPI receive decoder: reassembles bytes, tracks controller state from
// command bytes and emits frame-buffer write strobes for data bytes.
module pcd8544_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = pcd8544_pkg::COLS,
  parameter int ROWS        = pcd8544_pkg::ROWS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ce,
  input  logic       dc,
  input  logic       lcd_rst,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       fb_we,
  output logic [8:0] fb_addr,
  output logic [7:0] fb_data,
  output logic       pd,
  output logic       v_mode,
  output logic       h_ext,
  output logic [1:0] disp_mode,
  output logic [6:0] vop,
  output logic       err_partial,
  output logic [1:0] state_dbg
);
  import pcd8544_pkg::*;

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [2:0] Y_MAX = 3'(ROWS - 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic ce_s, ce_rise, ce_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic dc_s, dc_rise, dc_fall;
  logic rst_s, rst_rise, rst_fall;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ce (
    .clk(clk), .reset(reset), .d(ce), .q(ce_s), .rise(ce_rise), .fall(ce_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc (
    .clk(clk), .reset(reset), .d(dc), .q(dc_s), .rise(dc_rise), .fall(dc_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rst (
    .clk(clk), .reset(reset), .d(lcd_rst), .q(rst_s), .rise(rst_rise), .fall(rst_fall));

  assign unused_edges = ^{sclk_q, sclk_fall, ce_fall, mosi_rise, mosi_fall,
                          dc_rise, dc_fall, rst_rise, rst_fall};

  logic [1:0] state;
  logic [7:0] shreg, rx_byte;
  logic [2:0] bitcnt;
  logic       rx_dc;
  logic [6:0] x;
  logic [2:0] y;
  logic       shift_en, complete;

  // A ce rise in the same cycle as the 8th edge still counts as selected, so
  // that last bit is taken and the byte completes instead of aborting.
  assign shift_en  = sclk_rise && (!ce_s || ce_rise);
  assign complete  = shift_en && (bitcnt == 3'd7);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      rx_byte      <= '0;
      rx_dc        <= 1'b0;
      bitcnt       <= '0;
      x            <= '0;
      y            <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_data <= 1'b0;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
      pd           <= 1'b1;
      v_mode       <= 1'b0;
      h_ext        <= 1'b0;
      disp_mode    <= '0;
      vop          <= '0;
      err_partial  <= 1'b0;
    end else if (!rst_s) begin
      state       <= ST_IDLE;
      bitcnt      <= '0;
      x           <= '0;
      y           <= '0;
      pd          <= 1'b1;
      v_mode      <= 1'b0;
      h_ext       <= 1'b0;
      disp_mode   <= '0;
      vop         <= '0;
      byte_valid  <= 1'b0;
      fb_we       <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      fb_we       <= 1'b0;
      err_partial <= 1'b0;

      if (shift_en) begin
        shreg  <= {shreg[6:0], mosi_s};
        bitcnt <= bitcnt + 3'd1;
      end
      if (complete) begin
        rx_byte <= {shreg[6:0], mosi_s};
        rx_dc   <= dc_s;
      end

      if (complete) begin
        state <= ST_EXEC;
      end else if (ce_rise && bitcnt != 3'd0) begin
        bitcnt      <= '0;
        err_partial <= 1'b1;
        state       <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:  if (!ce_s) state <= ST_SHIFT;
          ST_SHIFT: if (ce_s) state <= ST_IDLE;
          ST_EXEC:  state <= ce_s ? ST_IDLE : ST_SHIFT;
          default:  state <= ST_IDLE;
        endcase
      end

      if (state == ST_EXEC) begin
        byte_valid   <= 1'b1;
        byte_data    <= rx_byte;
        byte_is_data <= rx_dc;
        if (rx_dc) begin
          fb_we   <= 1'b1;
          fb_addr <= fb_index(x, y);
          fb_data <= rx_byte;
        end
      end

      // Bytes take effect one edge after their byte_valid pulse.
      if (byte_valid && !byte_is_data) begin
        if ((byte_data & FUNC_SET_MASK) == FUNC_SET_VAL) begin
          pd     <= byte_data[2];
          v_mode <= byte_data[1];
          h_ext  <= byte_data[0];
        end else if (!h_ext) begin
          if ((byte_data & DISP_CTRL_MASK) == DISP_CTRL_VAL) begin
            disp_mode <= {byte_data[2], byte_data[0]};
          end else if ((byte_data & SET_Y_MASK) == SET_Y_VAL) begin
            if (byte_data[2:0] <= Y_MAX) y <= byte_data[2:0];
          end else if ((byte_data & SET_X_MASK) == SET_X_VAL) begin
            if (byte_data[6:0] <= X_MAX) x <= byte_data[6:0];
          end
        end else if ((byte_data & SET_VOP_MASK) == SET_VOP_VAL) begin
          vop <= byte_data[6:0];
        end
      end

      if (fb_we) begin
        if (!v_mode) begin
          if (x == X_MAX) begin
            x <= '0;
            y <= (y == Y_MAX) ? 3'd0 : y + 3'd1;
          end else begin
            x <= x + 7'd1;
          end
        end else begin
          if (y == Y_MAX) begin
            y <= '0;
            x <= (x == X_MAX) ? 7'd0 : x + 7'd1;
          end else begin
            y <= y + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pcd8544_rx.sv
// Self-checking bench for pcd8544_rx: directed vector table, hand-written
// corner sequences and randomized frames checked against a linear-index model.
module tb_pcd8544_rx;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       reset, sclk, mosi, ce, dc, lcd_rst;
  logic       byte_valid, byte_is_data, fb_we, pd, v_mode, h_ext, err_partial;
  logic [7:0] byte_data, fb_data;
  logic [8:0] fb_addr;
  logic [1:0] disp_mode, state_dbg;
  logic [6:0] vop;

  pcd8544_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ce(ce), .dc(dc),
    .lcd_rst(lcd_rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_is_data(byte_is_data), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .pd(pd), .v_mode(v_mode), .h_ext(h_ext),
    .disp_mode(disp_mode), .vop(vop), .err_partial(err_partial),
    .state_dbg(state_dbg));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_bv    = 0;
  int n_err   = 0;
  int n_sent  = 0;
  int exp_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every frame-buffer write must match the next queued data byte.
  always @(negedge clk) begin
    if (byte_valid) n_bv++;
    if (err_partial) n_err++;
    if (fb_we) begin
      if (exp_q.size() == 0) check("fb_unexpected", 1, 0);
      else check("fb_data_q", int'(fb_data), int'(exp_q.pop_front()));
    end
  end

  // Reference model over linear indices.
  int m_x, m_y, m_pd, m_v, m_h, m_disp, m_vop;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_pd = 1; m_v = 0; m_h = 0; m_disp = 0; m_vop = 0;
  endtask

  task automatic model_byte(input logic dcv, input logic [7:0] b, output int ea);
    int v, idx;
    v  = int'(b);
    ea = -1;
    if (dcv) begin
      ea = m_y * 84 + m_x;
      if (m_v == 0) begin
        idx = (ea + 1) % 504;
        m_x = idx % 84; m_y = idx / 84;
      end else begin
        idx = (m_x * 6 + m_y + 1) % 504;
        m_x = idx / 6; m_y = idx % 6;
      end
    end else if (v >= 32 && v < 40) begin
      m_pd = (v >> 2) & 1; m_v = (v >> 1) & 1; m_h = v & 1;
    end else if (m_h == 0) begin
      if (v >= 128) begin
        if (v - 128 < 84) m_x = v - 128;
      end else if (v >= 64 && v < 72) begin
        if (v - 64 < 6) m_y = v - 64;
      end else if (v >= 8 && v < 16 && ((v >> 1) & 1) == 0) begin
        m_disp = ((v >> 2) & 1) * 2 + (v & 1);
      end
    end else if (v >= 128) begin
      m_vop = v - 128;
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_pd"}, int'(pd), m_pd);
    check({tag, "_v"}, int'(v_mode), m_v);
    check({tag, "_h"}, int'(h_ext), m_h);
    check({tag, "_disp"}, int'(disp_mode), m_disp);
    check({tag, "_vop"}, int'(vop), m_vop);
  endtask

  // Driver: sclk low for lo clocks, high for 4; MSB first.
  task automatic spi_bits(input logic dcv, input logic [7:0] b, input int nbits, input int lo);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0; mosi = b[7-i]; dc = dcv;
      repeat (lo) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  int cap_we, cap_addr;

  task automatic xfer(input logic dcv, input logic [7:0] b, input bit ce_up);
    int lo, ea, lat;
    bit got;
    lo = $urandom_range(4, 6);
    if (dcv) exp_q.push_back(b);
    model_byte(dcv, b, ea);
    n_sent++;
    spi_bits(dcv, b, 7, lo);
    sclk = 1'b0; mosi = b[0]; dc = dcv;
    repeat (lo) @(negedge clk);
    sclk = 1'b1;
    if (ce_up) ce = 1'b1;
    got = 0; lat = 0; cap_we = -1; cap_addr = -1;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (c == 4) sclk = 1'b0;
      if (byte_valid) begin
        got = 1; lat = c;
        cap_we = int'(fb_we);
        cap_addr = fb_we ? int'(fb_addr) : -1;
        check("byte_data", int'(byte_data), int'(b));
        check("byte_is_data", int'(byte_is_data), int'(dcv));
      end
    end
    sclk = 1'b0;
    check("byte_timeout", int'(got), 1);
    check("latency", lat, SYNC_STAGES + 2);
    check("fb_we", cap_we, int'(dcv));
    check("fb_addr", cap_addr, ea);
    @(negedge clk);
    check("bv_single", int'(byte_valid), 0);
    check("we_single", int'(fb_we), 0);
    check_regs("regs");
  endtask

  task automatic ce_low();
    ce = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ce_high();
    ce = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic       dcv;
    logic [7:0] b;
    logic       e_pd, e_v, e_h;
    logic [1:0] e_disp;
    logic [6:0] e_vop;
    int         e_addr;
  } vec_t;

  vec_t tbl[24];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b0, 8'h21, 1'b0, 1'b0, 1'b1, 2'd0, 7'h00, -1};
    tbl[1]  = '{1'b0, 8'hBF, 1'b0, 1'b0, 1'b1, 2'd0, 7'h3F, -1};
    tbl[2]  = '{1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 2'd0, 7'h3F, -1};
    tbl[3]  = '{1'b0, 8'h45, 1'b0, 1'b0, 1'b0, 2'd0, 7'h3F, -1};
    tbl[4]  = '{1'b0, 8'h8A, 1'b0, 1'b0, 1'b0, 2'd0, 7'h3F, -1};
    tbl[5]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 2'd0, 7'h3F, 430};
    tbl[6]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 2'd0, 7'h3F, 431};
    tbl[7]  = '{1'b0, 8'hD3, 1'b0, 1'b0, 1'b0, 2'd0, 7'h3F, -1};
    tbl[8]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'd0, 7'h3F, 503};
    tbl[9]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2'd0, 7'h3F, 0};
    tbl[10] = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 2'd0, 7'h3F, -1};
    tbl[11] = '{1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 2'd0, 7'h3F, -1};
    tbl[12] = '{1'b0, 8'h45, 1'b0, 1'b1, 1'b0, 2'd0, 7'h3F, -1};
    tbl[13] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 2'd0, 7'h3F, 420};
    tbl[14] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 2'd0, 7'h3F, 1};
    tbl[15] = '{1'b0, 8'h47, 1'b0, 1'b1, 1'b0, 2'd0, 7'h3F, -1};
    tbl[16] = '{1'b0, 8'hD4, 1'b0, 1'b1, 1'b0, 2'd0, 7'h3F, -1};
    tbl[17] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 2'd0, 7'h3F, 85};
    tbl[18] = '{1'b0, 8'h0C, 1'b0, 1'b1, 1'b0, 2'd2, 7'h3F, -1};
    tbl[19] = '{1'b0, 8'h21, 1'b0, 1'b0, 1'b1, 2'd2, 7'h3F, -1};
    tbl[20] = '{1'b0, 8'h14, 1'b0, 1'b0, 1'b1, 2'd2, 7'h3F, -1};
    tbl[21] = '{1'b0, 8'h85, 1'b0, 1'b0, 1'b1, 2'd2, 7'h05, -1};
    tbl[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2, 7'h05, -1};
    tbl[23] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 2'd2, 7'h05, 169};

    // Clock/reset
    reset = 1'b0; sclk = 1'b0; mosi = 1'b0; ce = 1'b1; dc = 1'b0; lcd_rst = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_byte_valid", int'(byte_valid), 0);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_err", int'(err_partial), 0);
    check("rst_byte_data", int'(byte_data), 0);
    check("rst_is_data", int'(byte_is_data), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_data", int'(fb_data), 0);
    check_regs("rst");

    // Directed table in one ce frame (back-to-back bytes).
    ce_low();
    for (int i = 0; i < 24; i++) begin
      xfer(tbl[i].dcv, tbl[i].b, 1'b0);
      check($sformatf("tbl%0d_pd", i), int'(pd), int'(tbl[i].e_pd));
      check($sformatf("tbl%0d_v", i), int'(v_mode), int'(tbl[i].e_v));
      check($sformatf("tbl%0d_h", i), int'(h_ext), int'(tbl[i].e_h));
      check($sformatf("tbl%0d_disp", i), int'(disp_mode), int'(tbl[i].e_disp));
      check($sformatf("tbl%0d_vop", i), int'(vop), int'(tbl[i].e_vop));
      check($sformatf("tbl%0d_addr", i), cap_addr, tbl[i].e_addr);
    end
    ce_high();
    check("tbl_no_err", n_err, exp_err);

    // Abort after 5 bits, then a clean 0x0C.
    ce_low();
    xfer(1'b0, 8'h20, 1'b0);
    spi_bits(1'b0, 8'hFF, 5, 4);
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    ce = 1'b1;
    repeat (8) @(negedge clk);
    exp_err++;
    check("abort_err", n_err, exp_err);
    check("abort_no_bv", n_bv, n_sent);
    ce_low();
    xfer(1'b0, 8'h0C, 1'b0);
    check("abort_disp", int'(disp_mode), 2);
    ce_high();

    // 8th edge coincident with ce rising.
    ce_low();
    xfer(1'b0, 8'hC2, 1'b1);
    repeat (4) @(negedge clk);
    check("coinc_no_err", n_err, exp_err);
    check("coinc_bv", n_bv, n_sent);

    // lcd_rst mid-byte.
    ce_low();
    xfer(1'b0, 8'h23, 1'b0);
    spi_bits(1'b1, 8'hF0, 3, 4);
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    lcd_rst = 1'b0;
    repeat (5) @(negedge clk);
    lcd_rst = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
    check("lrst_no_bv", n_bv, n_sent);
    check_regs("lrst");
    ce_high();
    check("lrst_no_err", n_err, exp_err);
    ce_low();
    xfer(1'b1, 8'h77, 1'b0);
    check("lrst_addr0", cap_addr, 0);
    ce_high();

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      int nb;
      bit coinc;
      nb = $urandom_range(1, 8);
      coinc = bit'($urandom_range(0, 1));
      ce_low();
      for (int k = 0; k < nb; k++) begin
        logic       dcv;
        logic [7:0] b;
        dcv = logic'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
          0:       b = 8'h20 | 8'($urandom_range(0, 7));
          1:       b = 8'h40 | 8'($urandom_range(0, 7));
          2:       b = 8'h80 | 8'($urandom_range(0, 127));
          3:       b = 8'h08 | 8'($urandom_range(0, 7));
          4:       b = 8'($urandom_range(0, 255));
          default: b = 8'h00;
        endcase
        xfer(dcv, b, coinc && (k == nb - 1));
      end
      ce_high();
    end

    repeat (10) @(negedge clk);
    check("final_bv_count", n_bv, n_sent);
    check("final_err_count", n_err, exp_err);
    check("final_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcd8544_rx.md
# pcd8544_rx

Receive-side decoder for the PCD8544 (Nokia 5110) SPI link that the pet display driver transmits. It samples `sclk`/`mosi`/`ce`/`dc`/`lcd_rst` in the system clock domain and reassembles bytes. It interprets command bytes into controller state and turns data bytes into write strobes for a 504-byte frame-buffer mirror. It is used as an on-chip display monitor and as the checker endpoint for the LCD path.

## Interface

Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on each pin input; minimum 2.
- `COLS`, 84: columns per bank.
- `ROWS`, 6: banks (8-pixel rows).

Ports:
- `clk`  in  1  system clock, 50 MHz; must be at least 4× the `sclk` frequency.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `sclk`  in  1  SPI clock; data is sampled on its rising edge.
- `mosi`  in  1  serial data, MSB first.
- `ce`  in  1  chip enable, active-low.
- `dc`  in  1  0 = command byte, 1 = data byte.
- `lcd_rst`  in  1  LCD reset, active-low.
- `byte_valid`  out  1  one-cycle pulse per completed byte.
- `byte_data`  out  8  last completed byte; held until the next byte completes.
- `byte_is_data`  out  1  `dc` value latched with `byte_data`.
- `fb_we`  out  1  one-cycle frame-buffer write strobe.
- `fb_addr`  out  9  write address, `y*COLS + x`, range 0..503.
- `fb_data`  out  8  write data.
- `pd`  out  1  power-down bit.
- `v_mode`  out  1  vertical addressing.
- `h_ext`  out  1  extended instruction set.
- `disp_mode`  out  2  display control {D,E}.
- `vop`  out  7  operating-voltage setting.
- `err_partial`  out  1  one-cycle pulse when a byte is aborted.

## Operation

- Each pin passes through `SYNC_STAGES` flip-flops. `sclk` rising edge = synchronized `sclk` is 1 and its previous value was 0.
- On an `sclk` edge with synchronized `ce` = 0:
  - `shreg <= {shreg[6:0], mosi}`.
  - `bitcnt` increments.
  - On the 8th bit, the byte completes and the current `dc` is latched.
- States:
  - IDLE (`ce` high): wait for `ce` to fall, then go to SHIFT.
  - SHIFT: go to EXEC on byte completion.
  - EXEC (1 cycle): pulse `byte_valid`, apply the byte, then return to SHIFT, or to IDLE if `ce` is high.
- `ce` rising while `bitcnt` ≠ 0: discard the byte, set `bitcnt` = 0, pulse `err_partial`, go to IDLE.
- Command decode (`dc` = 0):
  - 0x00: NOP.
  - 0b00100PVH: function set; writes `pd`, `v_mode`, `h_ext`.
  - `h_ext` = 0:
    - 0b00001D0E: `disp_mode` <= {D,E}.
    - 0b01000yyy: set y if y ≤ 5, else ignored.
    - 0b1xxxxxxx: set x if x ≤ 83, else ignored.
  - `h_ext` = 1:
    - 0b1vvvvvvv: `vop` <= v.
    - Temperature and bias commands: accepted and ignored.
  - All other codes: ignored.
- Data byte (`dc` = 1):
  - `fb_we` = 1, `fb_addr` = current (x, y), `fb_data` = byte.
  - Address auto-increment when `v_mode` = 0: x++; at x = 84, x = 0 and y++; at y = 6, y = 0.
  - Address auto-increment when `v_mode` = 1: y++; at y = 6, y = 0 and x++; at x = 84, x = 0.
- Address arithmetic: `y*84 = (y<<6)+(y<<4)+(y<<2)`, 9 bits, no multiplier.
- Synchronized `lcd_rst` low:
  - Register values: x = 0, y = 0, `pd` = 1, `v_mode` = 0, `h_ext` = 0, `disp_mode` = 0, `vop` = 0, `bitcnt` = 0; state goes to IDLE.
  - Any in-flight byte is dropped without an `err_partial` pulse.
  - This has priority over every other event.

## Timing

- Reset values (`reset` low):
  - All pulses 0; `byte_data`, `fb_addr`, `fb_data` = 0; `byte_is_data` = 0.
  - `pd` = 1, `v_mode` = 0, `h_ext` = 0, `disp_mode` = 0, `vop` = 0; state IDLE.
- Latency: `byte_valid` and `fb_we` assert `SYNC_STAGES`+2 clk cycles after the 8th `sclk` rising edge is first sampled at the pin.
- `fb_we` is coincident with `byte_valid`. `fb_addr` carries the pre-increment address; x/y update on the following edge.
- Command effects are visible on outputs the cycle after `byte_valid`.
- 8th `sclk` edge and `ce` rising in the same cycle: the byte completes normally; no `err_partial`.
- Back-to-back bytes within one `ce` frame: `bitcnt` wraps 8→0 with no gap required.

## Structure

- Shared package `pcd8544_pkg`: `COLS`, `ROWS`, `FB_DEPTH` = 504, opcode masks/values (FUNC_SET, DISP_CTRL, SET_Y, SET_X, SET_VOP), FSM state encoding.
- Sub-module `sync_edge`: parameterized synchronizer plus rising/falling edge detector. One instance per pin; the `sclk` and `ce` instances use the edge outputs.
- Frame-buffer RAM sits outside this block.

## Test plan

- After reset, send command 0x21 then 0xBF → `h_ext` = 1, `vop` = 0x3F; `pd` = 0, `v_mode` = 0.
- With H = 0, send 0x45, 0x80+10, then data 0xA5 → `fb_we` pulse, `fb_addr` = 430, `fb_data` = 0xA5; next data byte is written at 431.
- Horizontal mode, x = 83, y = 5, two data bytes → `fb_addr` 503 then 0.
- Vertical mode (0x22), x = 0, y = 5, data → address 420; next data → address 1.
- Drop `ce` after 5 bits → one `err_partial` pulse, no `byte_valid`; a following full byte 0x0C → `disp_mode` = 2'b10.
- Pulse `lcd_rst` low mid-byte → no pulses; `pd` = 1, x = y = 0; the next byte decodes cleanly.
